// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF) and load/store (LS).
// Tracks the outstanding read latency and steers the returned data to the requester that owns it.
module mem_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              rd_en_o,
  output logic              wr_en_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam logic       SRC_IF   = 1'b0;
  localparam logic       SRC_LS   = 1'b1;
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state_reg, state_next;
  logic [2:0] lat_cnt_reg, lat_cnt_next;
  logic       owner_reg, owner_next;
  logic       last_gnt_reg, last_gnt_next;

  logic       rvalid_cycle;
  logic       grant_ok;
  logic       gnt_any;
  logic       gnt_src;
  logic       gnt_is_read;

  // Arbitration: a grant may issue in IDLE or on the final cycle of a pending read.
  always_comb begin
    rvalid_cycle = (state_reg == S_WAIT) && (lat_cnt_reg == 3'd1);
    grant_ok     = (state_reg == S_IDLE) || rvalid_cycle;
    gnt_any      = rstn_i && grant_ok && (if_req_i || ls_req_i);
    if (if_req_i && ls_req_i) begin
      gnt_src = ~last_gnt_reg;
    end else if (ls_req_i) begin
      gnt_src = SRC_LS;
    end else begin
      gnt_src = SRC_IF;
    end
    gnt_is_read = (gnt_src == SRC_IF) || !ls_we_i;
  end

  always_comb begin
    state_next    = state_reg;
    lat_cnt_next  = lat_cnt_reg;
    owner_next    = owner_reg;
    last_gnt_next = last_gnt_reg;
    if (gnt_any) begin
      last_gnt_next = gnt_src;
      if (gnt_is_read) begin
        state_next   = S_WAIT;
        lat_cnt_next = LAT_INIT;
        owner_next   = gnt_src;
      end else begin
        state_next   = S_IDLE;
        lat_cnt_next = 3'd0;
      end
    end else if (state_reg == S_WAIT) begin
      if (rvalid_cycle) begin
        state_next   = S_IDLE;
        lat_cnt_next = 3'd0;
      end else begin
        lat_cnt_next = lat_cnt_reg - 3'd1;
      end
    end
  end

  // last_gnt resets to LS so that IF wins the first conflict.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg    <= S_IDLE;
      lat_cnt_reg  <= 3'd0;
      owner_reg    <= SRC_IF;
      last_gnt_reg <= SRC_LS;
    end else begin
      state_reg    <= state_next;
      lat_cnt_reg  <= lat_cnt_next;
      owner_reg    <= owner_next;
      last_gnt_reg <= last_gnt_next;
    end
  end

  // Memory port drive: everything is zero unless a grant issues this cycle.
  always_comb begin
    if_gnt_o   = gnt_any && (gnt_src == SRC_IF);
    ls_gnt_o   = gnt_any && (gnt_src == SRC_LS);
    rd_en_o    = gnt_any && gnt_is_read;
    wr_en_o    = gnt_any && !gnt_is_read;
    addr_o     = '0;
    mem_data_o = '0;
    if (gnt_any) begin
      addr_o = (gnt_src == SRC_IF) ? if_addr_i : ls_addr_i;
    end
    if (wr_en_o) begin
      mem_data_o = ls_wdata_i;
    end
  end

  logic [1:0]        rvalid_vec;
  logic [DATA_W-1:0] rdata_arr [2];

  // Read return: only the owner sees rvalid, and rdata is forced to zero otherwise.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    assign rvalid_vec[gi] = rstn_i && rvalid_cycle && (owner_reg == 1'(gi));
    assign rdata_arr[gi]  = rvalid_vec[gi] ? mem_data_i : '0;
  end

  assign if_rvalid_o = rvalid_vec[0];
  assign ls_rvalid_o = rvalid_vec[1];
  assign if_rdata_o  = rdata_arr[0];
  assign ls_rdata_o  = rdata_arr[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
// Stimulus pushes expected grant/return events; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  typedef struct {
    int          dut;
    int          tag;
    logic [11:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] data;
  } ev_t;

  localparam int T_GIF = 0;
  localparam int T_GLS = 1;
  localparam int T_RIF = 2;
  localparam int T_RLS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn      [2];
  logic        if_req    [2];
  logic [11:0] if_addr   [2];
  logic        ls_req    [2];
  logic        ls_we     [2];
  logic [11:0] ls_addr   [2];
  logic [31:0] ls_wdata  [2];
  logic [31:0] mem_rdata [2];
  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        ls_gnt    [2];
  logic        ls_rvalid [2];
  logic [31:0] ls_rdata  [2];
  logic [11:0] addr      [2];
  logic        rd_en     [2];
  logic        wr_en     [2];
  logic [31:0] mem_wdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(12),
      .DATA_W(32),
      .RD_LAT((gi == 0) ? 1 : 3)
    ) u_dut (
      .clk_i      (clk),
      .rstn_i     (rstn[gi]),
      .if_req_i   (if_req[gi]),
      .if_addr_i  (if_addr[gi]),
      .if_gnt_o   (if_gnt[gi]),
      .if_rvalid_o(if_rvalid[gi]),
      .if_rdata_o (if_rdata[gi]),
      .ls_req_i   (ls_req[gi]),
      .ls_we_i    (ls_we[gi]),
      .ls_addr_i  (ls_addr[gi]),
      .ls_wdata_i (ls_wdata[gi]),
      .ls_gnt_o   (ls_gnt[gi]),
      .ls_rvalid_o(ls_rvalid[gi]),
      .ls_rdata_o (ls_rdata[gi]),
      .addr_o     (addr[gi]),
      .rd_en_o    (rd_en[gi]),
      .wr_en_o    (wr_en[gi]),
      .mem_data_o (mem_wdata[gi]),
      .mem_data_i (mem_rdata[gi])
    );
  end

  ev_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic string tag_name(input int tag);
    case (tag)
      T_GIF:   return "if_gnt";
      T_GLS:   return "ls_gnt";
      T_RIF:   return "if_rvalid";
      default: return "ls_rvalid";
    endcase
  endfunction

  task automatic exp(input int d, input int tag, input logic [11:0] a,
                     input logic rd, input logic wr, input logic [31:0] dat);
    ev_t e;
    e.dut = d; e.tag = tag; e.addr = a; e.rd = rd; e.wr = wr; e.data = dat;
    sb_q.push_back(e);
  endtask

  task automatic check_ev(input int d, input int tag, input logic [11:0] a,
                          input logic rd, input logic wr, input logic [31:0] dat);
    ev_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s dut%0d: got addr=%h rd=%0d wr=%0d data=%h, required no event",
               tag_name(tag), d, a, rd, wr, dat);
    end else begin
      e = sb_q.pop_front();
      if (e.dut != d || e.tag != tag || e.addr != a || e.rd != rd || e.wr != wr || e.data != dat) begin
        errors++;
        $display("FAIL %s dut%0d: got addr=%h rd=%0d wr=%0d data=%h, required %s dut%0d addr=%h rd=%0d wr=%0d data=%h",
                 tag_name(tag), d, a, rd, wr, dat, tag_name(e.tag), e.dut, e.addr, e.rd, e.wr, e.data);
      end else begin
        $display("%0t check %s dut%0d ok addr=%h rd=%0d wr=%0d data=%h",
                 $time, tag_name(tag), d, a, rd, wr, dat);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstn[d]) begin
        checks++;
        if (if_gnt[d] || ls_gnt[d] || if_rvalid[d] || ls_rvalid[d] || rd_en[d] || wr_en[d] ||
            addr[d] != 0 || mem_wdata[d] != 0 || if_rdata[d] != 0 || ls_rdata[d] != 0) begin
          errors++;
          $display("FAIL reset_outputs dut%0d: got gnt=%0d/%0d rv=%0d/%0d rd=%0d wr=%0d addr=%h, required all zero",
                   d, if_gnt[d], ls_gnt[d], if_rvalid[d], ls_rvalid[d], rd_en[d], wr_en[d], addr[d]);
        end
      end else begin
        if (if_rvalid[d]) check_ev(d, T_RIF, 12'h0, 1'b0, 1'b0, if_rdata[d]);
        if (ls_rvalid[d]) check_ev(d, T_RLS, 12'h0, 1'b0, 1'b0, ls_rdata[d]);
        checks++;
        if ((!if_rvalid[d] && if_rdata[d] != 0) || (!ls_rvalid[d] && ls_rdata[d] != 0)) begin
          errors++;
          $display("FAIL rdata_idle dut%0d: got if_rdata=%h ls_rdata=%h, required 0 without rvalid",
                   d, if_rdata[d], ls_rdata[d]);
        end
        checks++;
        if (if_gnt[d] && ls_gnt[d]) begin
          errors++;
          $display("FAIL single_gnt dut%0d: got if_gnt=1 ls_gnt=1, required at most one", d);
        end
        if (if_gnt[d] || ls_gnt[d]) begin
          check_ev(d, if_gnt[d] ? T_GIF : T_GLS, addr[d], rd_en[d], wr_en[d], mem_wdata[d]);
        end else begin
          checks++;
          if (rd_en[d] || wr_en[d] || addr[d] != 0 || mem_wdata[d] != 0) begin
            errors++;
            $display("FAIL port_idle dut%0d: got rd=%0d wr=%0d addr=%h data=%h, required all zero",
                     d, rd_en[d], wr_en[d], addr[d], mem_wdata[d]);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input int d);
    if_req[d] = 1'b0; if_addr[d] = '0;
    ls_req[d] = 1'b0; ls_we[d] = 1'b0; ls_addr[d] = '0; ls_wdata[d] = '0;
    mem_rdata[d] = '0;
  endtask

  task automatic pulse_reset(input int d, input int n);
    rstn[d] = 1'b0;
    repeat (n) cyc();
    rstn[d] = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle_inputs(d);
      rstn[d] = 1'b0;
    end
    // Requests held during reset must not leak through to the outputs.
    if_req[0] = 1'b1; if_addr[0] = 12'h7FC;
    ls_req[1] = 1'b1; ls_we[1] = 1'b1; ls_addr[1] = 12'h0F0; ls_wdata[1] = 32'hFFFF0000;
    repeat (3) cyc();
    idle_inputs(0); idle_inputs(1);
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    cyc();

    // Single IF read, RD_LAT=1.
    if_req[0] = 1'b1; if_addr[0] = 12'h010;
    exp(0, T_GIF, 12'h010, 1'b1, 1'b0, 32'h0);
    cyc();
    idle_inputs(0); mem_rdata[0] = 32'hDEADBEEF;
    exp(0, T_RIF, 12'h0, 1'b0, 1'b0, 32'hDEADBEEF);
    cyc();
    idle_inputs(0);
    cyc();

    // Conflict after reset: IF first, then LS write during the IF return cycle.
    pulse_reset(0, 2);
    cyc();
    if_req[0] = 1'b1; if_addr[0] = 12'h020;
    ls_req[0] = 1'b1; ls_we[0] = 1'b1; ls_addr[0] = 12'h100; ls_wdata[0] = 32'h12345678;
    exp(0, T_GIF, 12'h020, 1'b1, 1'b0, 32'h0);
    cyc();
    if_req[0] = 1'b0; if_addr[0] = '0; mem_rdata[0] = 32'hA5A50002;
    exp(0, T_RIF, 12'h0, 1'b0, 1'b0, 32'hA5A50002);
    exp(0, T_GLS, 12'h100, 1'b0, 1'b1, 32'h12345678);
    cyc();
    idle_inputs(0);
    cyc();

    // Both issuing reads continuously: grants alternate IF, LS, ...
    for (int k = 0; k < 6; k++) begin
      if_req[0] = 1'b1; if_addr[0] = 12'(12'h040 + 4 * ((k + 1) / 2));
      ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 12'(12'h200 + 4 * (k / 2));
      mem_rdata[0] = 32'h1000 + 32'(k);
      if (k > 0) exp(0, ((k - 1) % 2 == 0) ? T_RIF : T_RLS, 12'h0, 1'b0, 1'b0, 32'h1000 + 32'(k));
      if (k % 2 == 0) exp(0, T_GIF, if_addr[0], 1'b1, 1'b0, 32'h0);
      else            exp(0, T_GLS, ls_addr[0], 1'b1, 1'b0, 32'h0);
      cyc();
    end
    idle_inputs(0); mem_rdata[0] = 32'h1006;
    exp(0, T_RLS, 12'h0, 1'b0, 1'b0, 32'h1006);
    cyc();
    idle_inputs(0);
    cyc();

    // Back-to-back LS writes.
    for (int k = 0; k < 4; k++) begin
      ls_req[0] = 1'b1; ls_we[0] = 1'b1;
      ls_addr[0] = 12'(12'h300 + 4 * k); ls_wdata[0] = 32'hB0000000 + 32'(k);
      exp(0, T_GLS, ls_addr[0], 1'b0, 1'b1, ls_wdata[0]);
      cyc();
    end
    idle_inputs(0);
    cyc();

    // RD_LAT=3: LS write waits out the IF read, then issues on the return cycle.
    if_req[1] = 1'b1; if_addr[1] = 12'h030;
    exp(1, T_GIF, 12'h030, 1'b1, 1'b0, 32'h0);
    cyc();
    if_req[1] = 1'b0; if_addr[1] = '0;
    ls_req[1] = 1'b1; ls_we[1] = 1'b1; ls_addr[1] = 12'h104; ls_wdata[1] = 32'hCAFEF00D;
    cyc();
    cyc();
    mem_rdata[1] = 32'h33334444;
    exp(1, T_RIF, 12'h0, 1'b0, 1'b0, 32'h33334444);
    exp(1, T_GLS, 12'h104, 1'b0, 1'b1, 32'hCAFEF00D);
    cyc();
    idle_inputs(1);
    cyc();

    // RD_LAT=3: reset during an outstanding read discards it and restores IF priority.
    if_req[1] = 1'b1; if_addr[1] = 12'h050;
    exp(1, T_GIF, 12'h050, 1'b1, 1'b0, 32'h0);
    cyc();
    if_addr[1] = 12'h060;
    ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 12'h210;
    mem_rdata[1] = 32'h55550000;
    pulse_reset(1, 2);
    exp(1, T_GIF, 12'h060, 1'b1, 1'b0, 32'h0);
    cyc();
    if_req[1] = 1'b0; if_addr[1] = '0;
    cyc();
    cyc();
    mem_rdata[1] = 32'h66667777;
    exp(1, T_RIF, 12'h0, 1'b0, 1'b0, 32'h66667777);
    exp(1, T_GLS, 12'h210, 1'b1, 1'b0, 32'h0);
    cyc();
    idle_inputs(1);
    cyc();
    cyc();
    mem_rdata[1] = 32'h88889999;
    exp(1, T_RLS, 12'h0, 1'b0, 1'b0, 32'h88889999);
    cyc();
    idle_inputs(1);
    repeat (2) cyc();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending events, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
